// File: rtl/pwm_carrier.sv
// rtl/pwm_carrier.sv - parametrised triangle/sawtooth PWM carrier with prescaler, sync and event strobes
// Define PWM_CARRIER_SHADOW_EN to latch divider/carrier_max/mode only at reset, sync and the carrier valley.
module pwm_carrier #(
    parameter int CW = 16,
    parameter int DW = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          sys_ce,
    input  logic [DW-1:0] divider,
    input  logic [CW-1:0] carrier_max,
    input  logic [1:0]    mode,
    input  logic          sync_in,
    output logic [CW-1:0] carrier,
    output logic          dir,
    output logic          evt_valley,
    output logic          evt_peak
);

    localparam logic [1:0] MODE_SAW_UP = 2'b01;
    localparam logic [1:0] MODE_SAW_DN = 2'b10;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [CW-1:0] carrier_q, carrier_d;
    logic          dir_q, dir_d;
    logic          valley_q, valley_d;
    logic          peak_q, peak_d;

    logic [DW-1:0] div_a;
    logic [CW-1:0] max_a;
    logic [1:0]    mode_a;

    logic          tick;
    logic [CW-1:0] step_carrier;
    logic          step_dir;

    // >= rather than == so a divider shrunk below the running count ticks at once
    assign tick = sys_ce && (div_cnt_q >= div_a);

`ifdef PWM_CARRIER_SHADOW_EN
    logic [DW-1:0] div_sh_q;
    logic [CW-1:0] max_sh_q;
    logic [1:0]    mode_sh_q;
    logic          shadow_load;

    assign shadow_load = sys_rst || sync_in || (tick && (step_carrier == '0));

    always_ff @(posedge sys_clk) begin
        if (shadow_load) begin
            div_sh_q  <= divider;
            max_sh_q  <= carrier_max;
            mode_sh_q <= mode;
        end
    end

    assign div_a  = div_sh_q;
    assign max_a  = max_sh_q;
    assign mode_a = mode_sh_q;
`else
    assign div_a  = divider;
    assign max_a  = carrier_max;
    assign mode_a = mode;
`endif

    always_comb begin
        step_carrier = carrier_q;
        step_dir     = dir_q;
        if (max_a == '0) begin
            step_carrier = '0;
            step_dir     = 1'b1;
        end else begin
            case (mode_a)
                MODE_SAW_UP: begin
                    step_dir     = 1'b1;
                    step_carrier = (carrier_q < max_a) ? carrier_q + 1'b1 : '0;
                end
                MODE_SAW_DN: begin
                    // an out-of-range count simply walks down until it meets max_a
                    step_dir     = 1'b0;
                    step_carrier = (carrier_q > '0) ? carrier_q - 1'b1 : max_a;
                end
                default: begin
                    if ((carrier_q > max_a) || (dir_q && (carrier_q == max_a))) begin
                        step_carrier = max_a - 1'b1;
                        step_dir     = 1'b0;
                    end else if (dir_q) begin
                        step_carrier = carrier_q + 1'b1;
                    end else if (carrier_q > '0) begin
                        step_carrier = carrier_q - 1'b1;
                    end else begin
                        step_carrier = CW'(1);
                        step_dir     = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        div_cnt_d = div_cnt_q;
        carrier_d = carrier_q;
        dir_d     = dir_q;
        valley_d  = 1'b0;
        peak_d    = 1'b0;
        if (sync_in) begin
            div_cnt_d = '0;
            carrier_d = '0;
            dir_d     = 1'b1;
            valley_d  = 1'b1;
        end else if (sys_ce) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                carrier_d = step_carrier;
                dir_d     = step_dir;
                valley_d  = (step_carrier == '0);
                peak_d    = (step_carrier == max_a);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt_q <= '0;
            carrier_q <= '0;
            dir_q     <= 1'b1;
            valley_q  <= 1'b0;
            peak_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            carrier_q <= carrier_d;
            dir_q     <= dir_d;
            valley_q  <= valley_d;
            peak_q    <= peak_d;
        end
    end

    assign carrier    = carrier_q;
    assign dir        = dir_q;
    assign evt_valley = valley_q;
    assign evt_peak   = peak_q;

endmodule

// File: doc/pwm_carrier.md
# pwm_carrier

Parametrised PWM carrier generator for the inverter PWM path. It extends the fixed 8-bit triangle carrier with:
- configurable carrier and prescaler widths
- a programmable peak value
- triangle, sawtooth-up and sawtooth-down modes
- peak and valley event strobes
- an external phase-sync input
- optional shadow loading of settings at the carrier valley

Downstream PWM comparators and ADC trigger logic consume `carrier`, `dir` and the event strobes.

## Interface
- `CW`, 16, carrier counter width in bits.
- `DW`, 8, prescaler divider width in bits.

Ports:
- `sys_clk` in 1: system clock; all logic on its rising edge.
- `sys_rst` in 1: reset, synchronous, active-high.
- `sys_ce` in 1: clock enable; prescaler and carrier advance only while high.
- `divider` in DW: prescaler setting; one carrier step every divider+1 enabled cycles.
- `carrier_max` in CW: carrier peak value.
- `mode` in 2: 00 triangle, 01 sawtooth-up, 10 sawtooth-down, 11 triangle.
- `sync_in` in 1: one-cycle restart request.
- `carrier` out CW: carrier count.
- `dir` out 1: 1 while counting up, 0 while counting down.
- `evt_valley` out 1: one-cycle pulse when `carrier` becomes 0.
- `evt_peak` out 1: one-cycle pulse when `carrier` becomes max.

## Operation
- **Active settings.** Internal registers `div_a`, `max_a` and `mode_a` are used by all counting logic.
- **Prescaler.** `div_cnt` (DW bits) increments on each `sys_ce` cycle. When `div_cnt >= div_a`, it clears to 0 and generates a step tick. The `>=` compare makes a shrinking divider take effect without a wrap.
- **Step on tick, triangle mode.**
  - dir=1 and carrier < max_a: carrier+1.
  - dir=1 and carrier >= max_a: carrier <= max_a-1, dir <= 0.
  - dir=0 and carrier > 0: carrier-1.
  - dir=0 and carrier = 0: carrier <= 1, dir <= 1.
  - Period is 2·max_a ticks.
- **Step on tick, sawtooth-up mode.** carrier < max_a: carrier+1; otherwise carrier <= 0. dir is held at 1. Period is max_a+1 ticks.
- **Step on tick, sawtooth-down mode.** carrier > 0: carrier-1; otherwise carrier <= max_a. dir is held at 0. Period is max_a+1 ticks.
- **Out-of-range carrier.** If carrier > max_a after a max change, the next tick treats it as "at peak":
  - triangle: carrier <= max_a-1, dir <= 0
  - sawtooth-up: carrier <= 0
  - sawtooth-down: carrier-1, saturating at max_a
- **max_a = 0.** carrier is held at 0 and dir is 1. `evt_valley` and `evt_peak` both pulse on every tick.
- **Events.** Both strobes are registered and assert in the same cycle the new carrier value appears. They never assert while `sys_ce` is low, except the sync-generated valley pulse.
- **Sync.** `sync_in`=1 acts regardless of `sys_ce`:
  - carrier <= 0, dir <= 1, div_cnt <= 0
  - `evt_valley` pulses next cycle
  - active settings load from the inputs
- **Priority.** `sys_rst` > `sync_in` > tick.
- **Reset values.** carrier=0, dir=1, evt_valley=0, evt_peak=0, div_cnt=0. The active settings load `divider`/`carrier_max`/`mode` during reset.
- **Width rules.** All carrier arithmetic is CW-bit unsigned. The compares above prevent wrap past 0 or 2^CW-1.
- **Switching frequency.** Triangle: f_clk/(divider+1)/(2·max). Sawtooth: f_clk/(divider+1)/(max+1).

## Timing
- `carrier`, `dir` and the events update on the `sys_clk` edge where `sys_ce`=1 and `div_cnt >= div_a`. Latency from tick condition to output is one edge.
- `sync_in` sampled high at edge N: carrier=0 and evt_valley=1 after edge N. Counting resumes with a fresh prescaler count.
- Simultaneous sync and tick: sync wins and no step occurs.
- Reset asserted mid-period: all outputs take their reset values after the next edge. Reset asserted during a pending shadow update: the inputs are loaded directly.

## Configuration
`PWM_CARRIER_SHADOW_EN`:
- **Defined.**
  - Active settings load only at reset, at sync, and on the tick where carrier becomes 0 (the same cycle as `evt_valley`). They take effect from the following tick.
  - Mid-period changes to `divider`, `carrier_max` and `mode` are ignored until the next valley.
- **Undefined.** Active settings follow the inputs combinationally every cycle, and changes take effect on the next tick. The out-of-range rule bounds the result.

## Test plan
- **Triangle, baseline.** CW=8, divider=0, max=255, mode=00, sys_ce=1.
  - Carrier steps 0→255→0 with period 510 cycles.
  - evt_peak at 255, evt_valley at 0.
  - dir falls on the step to 254.
- **Prescaler and sawtooth.** divider=2, max=4, mode=01.
  - Carrier sequence 0,1,2,3,4,0, each value held 3 cycles.
  - evt_peak with 4, evt_valley with 0.
  - sys_ce low for 5 cycles freezes all state.
- **Sawtooth-down.** max=3, mode=10 from reset.
  - Sequence 0,3,2,1,0,3, with dir=0 after the first tick.
  - evt_peak with each 3.
- **Shadow loading, macro defined.** Change max from 10 to 5 at carrier=7 while counting up.
  - Carrier still reaches 10.
  - The next period peaks at 5.
  - Repeat with the macro undefined: next tick steps to 4 with dir=0.
- **Sync and reset.** Assert sync_in at carrier=6 together with a tick.
  - Next cycle carrier=0, evt_valley=1, no step.
  - sys_rst mid-count gives carrier=0, dir=1, events 0.
- **max=0.** Carrier is held at 0, and evt_valley and evt_peak pulse on every tick.
